spike_event_queue: RTL and testbench

Input buffer directly upstream of the 2-D convolution stage. Accepts spike events from the input interface, drops empty or out-of-range events, queues the rest in a FIFO, and presents them one at a time over the convolution's valid/ready/ack event handshake. It also enforces timestep ordering: an event from a new timestep is held back until the convolution has drained, and a one-cycle boundary pulse is emitted before it is released.

---
 rtl/spike_event_queue.sv | 107 ++++++++++
 tb/tb_spike_event_queue.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_event_queue.sv
// Spike event input queue: filters empty/out-of-range events, buffers them in a FIFO and
// releases them to the convolution stage one timestep at a time.
module spike_event_queue #(
   parameter int BITS_PER_COORDINATE = 8,
   parameter int IN_CHANNELS         = 2,
   parameter int IMG_WIDTH           = 32,
   parameter int IMG_HEIGHT          = 32,
   parameter int FIFO_DEPTH          = 16,
   parameter int DROP_CNT_BITS       = 16
) (
   input  logic                                         clk,
   input  logic                                         rst_n,
   input  logic                                         in_valid,
   output logic                                         in_ready,
   input  logic                                         in_timestep,
   input  logic [BITS_PER_COORDINATE-1:0]               in_x,
   input  logic [BITS_PER_COORDINATE-1:0]               in_y,
   input  logic [IN_CHANNELS-1:0]                       in_spikes,
   output logic                                         event_valid,
   output logic [2*BITS_PER_COORDINATE+IN_CHANNELS:0]   event_data,
   input  logic                                         conv_ready,
   input  logic                                         conv_ack,
   input  logic                                         convolution_active,
   output logic                                         timestep_boundary,
   output logic                                         current_timestep,
   output logic [$clog2(FIFO_DEPTH):0]                  fill_count,
   output logic [DROP_CNT_BITS-1:0]                     drop_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = 1 + 2*BITS_PER_COORDINATE + IN_CHANNELS;
   localparam logic [31:0] X_LIMIT = IMG_WIDTH;
   localparam logic [31:0] Y_LIMIT = IMG_HEIGHT;

   typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_BOUNDARY} state_t;

   state_t        state;
   logic [EW-1:0] mem [FIFO_DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic          empty;
   logic          full;
   logic          push;
   logic          in_range;
   logic          store;
   logic          drop;
   logic          pop;
   logic          head_ts;

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign in_ready = !full;
   assign push     = in_valid && !full;
   assign in_range = (32'(in_x) < X_LIMIT) && (32'(in_y) < Y_LIMIT);
   assign store    = push && (|in_spikes) && in_range;
   assign drop     = push && !store;

   assign event_data = mem[rd_ptr[AW-1:0]];
   assign head_ts    = event_data[EW-1];
   assign pop        = conv_ack && !empty && (state == ST_RUN);

   // Head is only offered while it belongs to the timestep being processed.
   assign event_valid       = (state == ST_RUN) && !empty && (head_ts == current_timestep);
   assign timestep_boundary = (state == ST_BOUNDARY);
   assign fill_count        = wr_ptr - rd_ptr;

   // NOTE: storage has no reset; the pointers alone decide which entries are live, so
   // stale contents after reset can never be presented as a valid event.
   always_ff @(posedge clk) begin
      if (store)
         mem[wr_ptr[AW-1:0]] <= {in_timestep, in_x, in_y, in_spikes};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr           <= '0;
         rd_ptr           <= '0;
         drop_count       <= '0;
         current_timestep <= 1'b0;
         state            <= ST_RUN;
      end else begin
         if (store)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (drop && (drop_count != '1))
            drop_count <= drop_count + 1'b1;

         unique case (state)
            ST_RUN: begin
               if (!empty && (head_ts != current_timestep))
                  state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (conv_ready && !convolution_active)
                  state <= ST_BOUNDARY;
            end
            ST_BOUNDARY: begin
               current_timestep <= !current_timestep;
               state            <= ST_RUN;
            end
            default: state <= ST_RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_spike_event_queue.sv
// Directed self-checking bench for spike_event_queue: filtering, FIFO order across wrap,
// timestep drain/boundary sequencing and mid-operation reset.
module tb_spike_event_queue;

   localparam int B  = 8;
   localparam int C  = 2;
   localparam int EW = 1 + 2*B + C;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic          in_timestep;
   logic [B-1:0]  in_x;
   logic [B-1:0]  in_y;
   logic [C-1:0]  in_spikes;
   logic          event_valid;
   logic [EW-1:0] event_data;
   logic          conv_ready;
   logic          conv_ack;
   logic          convolution_active;
   logic          timestep_boundary;
   logic          current_timestep;
   logic [4:0]    fill_count;
   logic [15:0]   drop_count;

   int n_checks = 0;
   int n_pass   = 0;
   logic [EW-1:0] q[$];

   spike_event_queue dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .in_valid           (in_valid),
      .in_ready           (in_ready),
      .in_timestep        (in_timestep),
      .in_x               (in_x),
      .in_y               (in_y),
      .in_spikes          (in_spikes),
      .event_valid        (event_valid),
      .event_data         (event_data),
      .conv_ready         (conv_ready),
      .conv_ack           (conv_ack),
      .convolution_active (convolution_active),
      .timestep_boundary  (timestep_boundary),
      .current_timestep   (current_timestep),
      .fill_count         (fill_count),
      .drop_count         (drop_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // Inputs change and outputs are sampled 1ns after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [EW-1:0] pack(input logic ts, input logic [B-1:0] x,
                                          input logic [B-1:0] y, input logic [C-1:0] sp);
      return {ts, x, y, sp};
   endfunction

   task automatic drive(input logic ts, input logic [B-1:0] x, input logic [B-1:0] y,
                        input logic [C-1:0] sp);
      in_valid    = 1'b1;
      in_timestep = ts;
      in_x        = x;
      in_y        = y;
      in_spikes   = sp;
   endtask

   task automatic push_one(input logic ts, input logic [B-1:0] x, input logic [B-1:0] y,
                           input logic [C-1:0] sp);
      drive(ts, x, y, sp);
      step();
      in_valid = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_ev_valid"}, 32'(event_valid), 32'd0);
      check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      check({tag, "_fill"}, 32'(fill_count), 32'd0);
      check({tag, "_drop"}, 32'(drop_count), 32'd0);
      check({tag, "_cur_ts"}, 32'(current_timestep), 32'd0);
      check({tag, "_boundary"}, 32'(timestep_boundary), 32'd0);
   endtask

   function automatic logic [B-1:0] wx(input int i);
      return B'(i % 32);
   endfunction

   function automatic logic [B-1:0] wy(input int i);
      return B'((i * 7) % 32);
   endfunction

   function automatic logic [C-1:0] wsp(input int i);
      return C'((i % 3) + 1);
   endfunction

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_timestep = 1'b0; in_x = '0; in_y = '0;
      in_spikes = '0; conv_ready = 1'b0; conv_ack = 1'b0; convolution_active = 1'b0;
      #1;
      step();
      rst_n = 1'b1;
      check_reset_state("por");

      // Single event: one-cycle latency, then pop.
      push_one(1'b0, 8'd3, 8'd4, 2'b01);
      check("lat_valid", 32'(event_valid), 32'd1);
      check("lat_data", 32'(event_data), 32'(pack(1'b0, 8'd3, 8'd4, 2'b01)));
      conv_ack = 1'b1;
      step();
      conv_ack = 1'b0;
      check("pop_valid", 32'(event_valid), 32'd0);
      check("pop_fill", 32'(fill_count), 32'd0);

      // Filtered events are accepted but not stored.
      drive(1'b0, 8'd1, 8'd1, 2'b00);
      check("drop0_ready", 32'(in_ready), 32'd1);
      step();
      drive(1'b0, 8'd32, 8'd1, 2'b11);
      check("drop1_ready", 32'(in_ready), 32'd1);
      step();
      drive(1'b0, 8'd31, 8'd32, 2'b10);
      check("drop2_ready", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      check("drop_count", 32'(drop_count), 32'd3);
      check("drop_fill", 32'(fill_count), 32'd0);
      check("drop_valid", 32'(event_valid), 32'd0);

      // Fill to full, refused push while full (even alongside a pop), then wrap.
      for (int i = 0; i < 16; i++) begin
         push_one(1'b0, wx(i), wy(i), wsp(i));
         q.push_back(pack(1'b0, wx(i), wy(i), wsp(i)));
      end
      check("full_fill", 32'(fill_count), 32'd16);
      check("full_ready", 32'(in_ready), 32'd0);
      drive(1'b0, wx(16), wy(16), wsp(16));
      step();
      check("full_refused", 32'(fill_count), 32'd16);
      check("full_head", 32'(event_data), 32'(q[0]));
      conv_ack = 1'b1;
      step();
      conv_ack = 1'b0;
      void'(q.pop_front());
      check("full_pop_fill", 32'(fill_count), 32'd15);
      check("full_pop_ready", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      q.push_back(pack(1'b0, wx(16), wy(16), wsp(16)));
      check("refill", 32'(fill_count), 32'd16);
      conv_ack = 1'b1;
      step();
      conv_ack = 1'b0;
      void'(q.pop_front());
      for (int i = 17; i < 40; i++) begin
         check($sformatf("wrap_valid%0d", i), 32'(event_valid), 32'd1);
         check($sformatf("wrap_data%0d", i), 32'(event_data), 32'(q[0]));
         drive(1'b0, wx(i), wy(i), wsp(i));
         conv_ack = 1'b1;
         step();
         void'(q.pop_front());
         q.push_back(pack(1'b0, wx(i), wy(i), wsp(i)));
         check($sformatf("wrap_fill%0d", i), 32'(fill_count), 32'd15);
      end
      in_valid = 1'b0;
      conv_ack = 1'b0;
      while (q.size() > 0) begin
         check("drain_valid", 32'(event_valid), 32'd1);
         check("drain_data", 32'(event_data), 32'(q[0]));
         conv_ack = 1'b1;
         step();
         conv_ack = 1'b0;
         void'(q.pop_front());
      end
      check("drain_fill", 32'(fill_count), 32'd0);
      check("drain_empty_valid", 32'(event_valid), 32'd0);

      // Timestep change: B (ts1) waits for the convolution to go idle.
      push_one(1'b0, 8'd5, 8'd6, 2'b10);
      push_one(1'b1, 8'd7, 8'd8, 2'b11);
      check("ts_a_valid", 32'(event_valid), 32'd1);
      check("ts_a_data", 32'(event_data), 32'(pack(1'b0, 8'd5, 8'd6, 2'b10)));
      conv_ack = 1'b1;
      convolution_active = 1'b1;
      conv_ready = 1'b1;
      step();
      conv_ack = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("ts_hold_valid%0d", k), 32'(event_valid), 32'd0);
         check($sformatf("ts_hold_bnd%0d", k), 32'(timestep_boundary), 32'd0);
         check($sformatf("ts_hold_cur%0d", k), 32'(current_timestep), 32'd0);
         step();
      end
      convolution_active = 1'b0;
      step();
      check("ts_bnd_pulse", 32'(timestep_boundary), 32'd1);
      check("ts_bnd_valid", 32'(event_valid), 32'd0);
      check("ts_bnd_cur", 32'(current_timestep), 32'd0);
      step();
      check("ts_bnd_end", 32'(timestep_boundary), 32'd0);
      check("ts_new_cur", 32'(current_timestep), 32'd1);
      check("ts_b_valid", 32'(event_valid), 32'd1);
      check("ts_b_data", 32'(event_data), 32'(pack(1'b1, 8'd7, 8'd8, 2'b11)));
      conv_ack = 1'b1;
      step();
      conv_ack = 1'b0;
      check("ts_b_popped", 32'(fill_count), 32'd0);

      // Mid-operation reset with queued events and a nonzero drop count.
      for (int i = 0; i < 4; i++) push_one(1'b1, 8'd2, 8'd2, 2'b00);
      for (int i = 0; i < 5; i++) push_one(1'b1, 8'(20 + i), 8'd9, 2'b01);
      check("pre_rst_fill", 32'(fill_count), 32'd5);
      check("pre_rst_drop", 32'(drop_count), 32'd7);
      check("pre_rst_valid", 32'(event_valid), 32'd1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check_reset_state("mid");
      step();
      check("post_rst_idle_valid", 32'(event_valid), 32'd0);
      push_one(1'b0, 8'd9, 8'd10, 2'b01);
      check("post_rst_valid", 32'(event_valid), 32'd1);
      check("post_rst_data", 32'(event_data), 32'(pack(1'b0, 8'd9, 8'd10, 2'b01)));
      check("post_rst_fill", 32'(fill_count), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
